// File: rtl/cascade_down_up_counter_pkg.sv
// Shared definitions for the cascaded down/up counter pair:
// default sizing, the count type and its end-of-range constants.
package cnt_pkg;

  localparam int DEF_WIDTH     = 4;
  localparam int DEF_MATCH_VAL = 3;

  typedef logic [DEF_WIDTH-1:0] cnt_t;

  localparam cnt_t CNT_MAX  = cnt_t'((2 ** DEF_WIDTH) - 1);
  localparam cnt_t CNT_ZERO = '0;

endpackage

// File: rtl/cascade_down_up_counter_if.sv
// Control and status bundle for cascade_down_up_counter.
// The master side drives enable/load, the slave side (the counter) returns
// the registered counts and flags.
interface cascade_down_up_counter_if
  import cnt_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) ();

  logic             en;
  logic             load;
  logic [WIDTH-1:0] load_a;
  logic [WIDTH-1:0] load_b;
  logic [WIDTH-1:0] count_a;
  logic [WIDTH-1:0] count_b;
  logic             match;
  logic             b_wrap;

  modport master (
    output en, load, load_a, load_b,
    input  count_a, count_b, match, b_wrap
  );

  modport slave (
    input  en, load, load_a, load_b,
    output count_a, count_b, match, b_wrap
  );

endinterface

// File: rtl/cascade_down_up_counter_wrap_counter.sv
// Loadable modulo-2**WIDTH counter stepping up or down by one.
// wrap is a combinational look-ahead: it is high when the coming edge will
// roll the count over its end of range, so the parent can register it.
module wrap_counter
  import cnt_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter bit UP    = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] rst_val,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             step,
  output logic [WIDTH-1:0] q,
  output logic             wrap
);

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_next;
  logic [WIDTH-1:0] w_edgeVal;

  assign w_next    = UP ? (r_q + 1'b1) : (r_q - 1'b1);
  assign w_edgeVal = UP ? {WIDTH{1'b1}} : {WIDTH{1'b0}};
  assign wrap      = step & ~load & (r_q == w_edgeVal);
  assign q         = r_q;

  // Count register: load beats step, otherwise hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q <= rst_val;
    end else if (load) begin
      r_q <= load_val;
    end else if (step) begin
      r_q <= w_next;
    end
  end

endmodule

// File: rtl/cascade_down_up_counter.sv
// Two-stage cascade: count_a counts down on every enabled edge, count_b
// counts up once each time count_a leaves MATCH_VAL. match and b_wrap are
// registered here so every output comes straight from a flop.
module cascade_down_up_counter
  import cnt_pkg::*;
#(
  parameter int               WIDTH     = DEF_WIDTH,
  parameter logic [WIDTH-1:0] MATCH_VAL = WIDTH'(DEF_MATCH_VAL),
  parameter logic [WIDTH-1:0] A_INIT    = {WIDTH{1'b1}},
  parameter logic [WIDTH-1:0] B_INIT    = {WIDTH{1'b0}}
) (
  input  logic                     clk,
  input  logic                     rst,
  cascade_down_up_counter_if.slave bus
);

  logic [WIDTH-1:0] w_countA;
  logic [WIDTH-1:0] w_countB;
  logic [WIDTH-1:0] w_nextA;
  logic             w_stepB;
  logic             w_wrapB;
  logic             r_match;
  logic             r_bWrap;

  // count_b only advances on the enabled edge that moves count_a off MATCH_VAL.
  assign w_stepB = bus.en & (w_countA == MATCH_VAL);

  wrap_counter #(
    .WIDTH (WIDTH),
    .UP    (1'b0)
  ) u_countA (
    .clk      (clk),
    .rst      (rst),
    .rst_val  (A_INIT),
    .load     (bus.load),
    .load_val (bus.load_a),
    .step     (bus.en),
    .q        (w_countA),
    .wrap     ()
  );

  wrap_counter #(
    .WIDTH (WIDTH),
    .UP    (1'b1)
  ) u_countB (
    .clk      (clk),
    .rst      (rst),
    .rst_val  (B_INIT),
    .load     (bus.load),
    .load_val (bus.load_b),
    .step     (w_stepB),
    .q        (w_countB),
    .wrap     (w_wrapB)
  );

  // Predict the value count_a takes on this edge so match can be registered.
  always_comb begin
    w_nextA = w_countA;
    if (bus.load) begin
      w_nextA = bus.load_a;
    end else if (bus.en) begin
      w_nextA = w_countA - 1'b1;
    end
  end

  // Registered flags: match tracks count_a, b_wrap is a single-cycle pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_match <= (A_INIT == MATCH_VAL);
      r_bWrap <= 1'b0;
    end else begin
      r_match <= (w_nextA == MATCH_VAL);
      r_bWrap <= w_wrapB;
    end
  end

  assign bus.count_a = w_countA;
  assign bus.count_b = w_countB;
  assign bus.match   = r_match;
  assign bus.b_wrap  = r_bWrap;

endmodule
